// File: rtl/harmonic_scheduler_pkg.sv
// Shared types and constants for the harmonic mixing scheduler.
package harmonic_scheduler_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned SCALE_W  = 16;
  localparam int unsigned HARM_W   = 8;
  localparam int unsigned PROD_W   = SAMPLE_W + 1;

  localparam logic [SCALE_W-1:0]         SCALE_INIT = 16'hFFFF;
  localparam int unsigned                OUT_SHIFT  = 4;
  localparam logic signed [SAMPLE_W-1:0] SAT_MAX    = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN    = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    WAIT_LUT,
    ACCUM,
    NEXT,
    OUTPUT
  } state_t;

endpackage

// File: rtl/harmonic_weight.sv
// Registered signed x unsigned multiply, returning the product scaled down by 2^16.
module harmonic_weight
  import harmonic_scheduler_pkg::*;
(
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic signed [PROD_W-1:0] i_A,
  input  logic [SCALE_W-1:0]       i_B,
  output logic signed [PROD_W-1:0] o_Product
);

  localparam int unsigned FULL_W = 2 * PROD_W;

  logic signed [FULL_W-1:0] w_Full;
  logic signed [PROD_W-1:0] r_Product;

  // Full-precision product; operands widened first so the multiply is exact.
  always_comb begin
    w_Full = FULL_W'(i_A) * FULL_W'($signed({1'b0, i_B}));
  end

  // Register the floor-scaled product.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Product <= '0;
    end else begin
      r_Product <= PROD_W'(w_Full >>> 16);
    end
  end

  assign o_Product = r_Product;

endmodule

// File: rtl/harmonic_scheduler.sv
// Walks harmonics through the position block once per sample tick and mixes
// the geometrically weighted sine values into one saturated output sample.
module harmonic_scheduler
  import harmonic_scheduler_pkg::*;
#(
  parameter int unsigned MAX_HARMONICS = 64,
  parameter int unsigned ACC_W         = 25
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Sample_Tick,
  input  logic [HARM_W-1:0]          i_Harmonic_Count,
  input  logic [SCALE_W-1:0]         i_Rolloff,
  output logic [HARM_W-1:0]          o_Harmonic,
  input  logic                       i_Sample_Ready,
  output logic                       o_Next_Sample,
  input  logic signed [SAMPLE_W-1:0] i_Sample_Value,
  input  logic                       i_Freq_Too_High,
  output logic signed [SAMPLE_W-1:0] o_Sample,
  output logic                       o_Sample_Valid,
  output logic                       o_Busy,
  output logic                       o_Overrun
);

  localparam logic [HARM_W-1:0]      HARM_MAX = HARM_W'(MAX_HARMONICS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

  state_t                     r_State, w_State;
  logic [HARM_W-1:0]          r_Harmonic, w_Harmonic;
  logic                       r_Next_Sample, w_Next_Sample;
  logic signed [SAMPLE_W-1:0] r_Sample, w_Sample;
  logic                       r_Sample_Valid, w_Sample_Valid;
  logic                       r_Busy, w_Busy;
  logic                       r_Overrun, w_Overrun;
  logic signed [ACC_W-1:0]    r_Acc, w_Acc;
  logic [SCALE_W-1:0]         r_Scale, w_Scale;
  logic [HARM_W-1:0]          r_Count, w_Count;
  logic                       r_Last, w_Last;

  logic signed [PROD_W-1:0]   w_Weighted;
  logic signed [PROD_W-1:0]   w_Decay;
  logic signed [ACC_W-1:0]    w_Shifted;
  logic signed [SAMPLE_W-1:0] w_Sat;

  // Sine value weighted by the current amplitude scale (captured during WAIT_LUT).
  harmonic_weight u_weight (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_A       ({i_Sample_Value[SAMPLE_W-1], i_Sample_Value}),
    .i_B       (r_Scale),
    .o_Product (w_Weighted)
  );

  // Amount the scale shrinks by for the next harmonic.
  harmonic_weight u_decay (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_A       ({1'b0, r_Scale}),
    .i_B       (i_Rolloff),
    .o_Product (w_Decay)
  );

  // Scale the accumulator to output range and clamp to 16-bit signed.
  always_comb begin
    w_Shifted = r_Acc >>> OUT_SHIFT;
    if (w_Shifted > ACC_MAX) begin
      w_Sat = SAT_MAX;
    end else if (w_Shifted < ACC_MIN) begin
      w_Sat = SAT_MIN;
    end else begin
      w_Sat = w_Shifted[SAMPLE_W-1:0];
    end
  end

  // Next-state and next-output logic; every output is the registered copy of these.
  always_comb begin
    w_State        = r_State;
    w_Harmonic     = r_Harmonic;
    w_Next_Sample  = 1'b0;
    w_Sample       = r_Sample;
    w_Sample_Valid = 1'b0;
    w_Busy         = r_Busy;
    w_Overrun      = r_Overrun;
    w_Acc          = r_Acc;
    w_Scale        = r_Scale;
    w_Count        = r_Count;
    w_Last         = r_Last;

    if (i_Sample_Tick && (r_State != IDLE)) begin
      w_Overrun = 1'b1;
    end

    case (r_State)
      IDLE: begin
        if (i_Sample_Tick) begin
          w_Acc      = '0;
          w_Scale    = SCALE_INIT;
          w_Harmonic = '0;
          w_Count    = (i_Harmonic_Count > HARM_MAX) ? HARM_MAX : i_Harmonic_Count;
          w_Last     = 1'b0;
          w_Busy     = 1'b1;
          w_State    = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (i_Sample_Ready) begin
          w_State = WAIT_LUT;
        end
      end
      WAIT_LUT: begin
        w_State = ACCUM;
      end
      ACCUM: begin
        if (!i_Freq_Too_High) begin
          w_Acc = r_Acc + ACC_W'(w_Weighted);
        end
        w_Scale       = SCALE_W'({1'b0, r_Scale} - $unsigned(w_Decay));
        w_Last        = i_Freq_Too_High || (r_Harmonic == r_Count);
        // Address is updated together with the strobe; 0 on the final harmonic.
        w_Harmonic    = w_Last ? '0 : r_Harmonic + 8'd1;
        w_Next_Sample = 1'b1;
        w_State       = NEXT;
      end
      NEXT: begin
        if (r_Last) begin
          w_Sample       = w_Sat;
          w_Sample_Valid = 1'b1;
          w_Busy         = 1'b0;
          w_State        = OUTPUT;
        end else begin
          w_State = WAIT_READY;
        end
      end
      OUTPUT: begin
        w_State = IDLE;
      end
      default: begin
        w_State = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State        <= IDLE;
      r_Harmonic     <= '0;
      r_Next_Sample  <= 1'b0;
      r_Sample       <= '0;
      r_Sample_Valid <= 1'b0;
      r_Busy         <= 1'b0;
      r_Overrun      <= 1'b0;
      r_Acc          <= '0;
      r_Scale        <= SCALE_INIT;
      r_Count        <= '0;
      r_Last         <= 1'b0;
    end else begin
      r_State        <= w_State;
      r_Harmonic     <= w_Harmonic;
      r_Next_Sample  <= w_Next_Sample;
      r_Sample       <= w_Sample;
      r_Sample_Valid <= w_Sample_Valid;
      r_Busy         <= w_Busy;
      r_Overrun      <= w_Overrun;
      r_Acc          <= w_Acc;
      r_Scale        <= w_Scale;
      r_Count        <= w_Count;
      r_Last         <= w_Last;
    end
  end

  assign o_Harmonic     = r_Harmonic;
  assign o_Next_Sample  = r_Next_Sample;
  assign o_Sample       = r_Sample;
  assign o_Sample_Valid = r_Sample_Valid;
  assign o_Busy         = r_Busy;
  assign o_Overrun      = r_Overrun;

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Directed bench for harmonic_scheduler with a simple position-block responder.
module tb_harmonic_scheduler;

  localparam int DELAY = 3;

  logic               i_Clock;
  logic               i_Reset;
  logic               i_Sample_Tick;
  logic [7:0]         i_Harmonic_Count;
  logic [15:0]        i_Rolloff;
  logic [7:0]         o_Harmonic;
  logic               i_Sample_Ready;
  logic               o_Next_Sample;
  logic signed [15:0] i_Sample_Value;
  logic               i_Freq_Too_High;
  logic signed [15:0] o_Sample;
  logic               o_Sample_Valid;
  logic               o_Busy;
  logic               o_Overrun;

  int n_checks = 0;
  int n_err    = 0;

  logic signed [15:0] vals [64];
  logic [7:0]         pulse_h [256];

  harmonic_scheduler #(.MAX_HARMONICS(64), .ACC_W(25)) dut (
    .i_Clock          (i_Clock),
    .i_Reset          (i_Reset),
    .i_Sample_Tick    (i_Sample_Tick),
    .i_Harmonic_Count (i_Harmonic_Count),
    .i_Rolloff        (i_Rolloff),
    .o_Harmonic       (o_Harmonic),
    .i_Sample_Ready   (i_Sample_Ready),
    .o_Next_Sample    (o_Next_Sample),
    .i_Sample_Value   (i_Sample_Value),
    .i_Freq_Too_High  (i_Freq_Too_High),
    .o_Sample         (o_Sample),
    .o_Sample_Valid   (o_Sample_Valid),
    .o_Busy           (o_Busy),
    .o_Overrun        (o_Overrun)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [15:0] v);
    for (int i = 0; i < 64; i++) vals[i] = v;
  endtask

  // One sample period: tick, then answer ready/value per harmonic until valid.
  task automatic run_period(input logic [7:0] cnt, input logic [15:0] roll, input int ftoh,
                            input int tick2, input int rst_h, output int lat,
                            output logic signed [15:0] smp, output int npulse,
                            output int nvalid, output int nviol);
    int wc = 0;
    int c = 1;
    bit done = 1'b0;
    bit rdy_seen = 1'b0;
    bit prev_ns = 1'b0;
    bit rdy_d1 = 1'b0;
    bit rdy_d2 = 1'b0;
    lat = -1; smp = '0; npulse = 0; nvalid = 0; nviol = 0;
    i_Harmonic_Count = cnt;
    i_Rolloff = roll;
    i_Sample_Tick = 1'b1;
    step();
    i_Sample_Tick = 1'b0;
    while (!done && c < 2000) begin
      if (rst_h >= 0 && int'(o_Harmonic) == rst_h && rdy_d1 && !rdy_d2) begin
        i_Reset = 1'b1;
        i_Sample_Ready = 1'b0;
        step();
        done = 1'b1;
      end else begin
        i_Sample_Ready  = o_Busy && (wc >= DELAY - 1);
        i_Sample_Value  = vals[o_Harmonic[5:0]];
        i_Freq_Too_High = (int'(o_Harmonic) == ftoh);
        i_Sample_Tick   = (c == tick2);
        if (o_Next_Sample) begin
          if (prev_ns || !rdy_seen) nviol++;
          pulse_h[npulse] = o_Harmonic;
          npulse++;
          wc = 0;
          rdy_seen = 1'b0;
        end else begin
          wc++;
          if (i_Sample_Ready) rdy_seen = 1'b1;
        end
        if (o_Sample_Valid) begin
          lat = c;
          smp = o_Sample;
          nvalid++;
          if (o_Busy) nviol++;
          done = 1'b1;
        end
        prev_ns = o_Next_Sample;
        rdy_d2 = rdy_d1;
        rdy_d1 = i_Sample_Ready;
        step();
        c++;
      end
    end
    i_Sample_Tick = 1'b0;
    i_Sample_Ready = 1'b0;
    i_Freq_Too_High = 1'b0;
    if (lat >= 0) begin
      repeat (4) begin
        if (o_Sample_Valid) nvalid++;
        if (o_Next_Sample) nviol++;
        step();
      end
    end
  endtask

  initial begin
    int lat, np, nv, nvi;
    logic signed [15:0] smp;

    i_Reset = 1'b1; i_Sample_Tick = 1'b0; i_Harmonic_Count = '0; i_Rolloff = '0;
    i_Sample_Ready = 1'b0; i_Sample_Value = '0; i_Freq_Too_High = 1'b0;
    repeat (3) step();
    check("rst_harmonic", o_Harmonic, 0);
    check("rst_next", o_Next_Sample, 0);
    check("rst_sample", o_Sample, 0);
    check("rst_valid", o_Sample_Valid, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_overrun", o_Overrun, 0);
    i_Reset = 1'b0;
    step();

    // Single harmonic, full scale: 16384*65535>>16 = 16383, >>>4 = 1023.
    fill(16'sd16384);
    run_period(8'd0, 16'h0000, -1, -1, -1, lat, smp, np, nv, nvi);
    check("t1_latency", lat, 7);
    check("t1_sample", smp, 1023);
    check("t1_pulses", np, 1);
    check("t1_pulse_harm", pulse_h[0], 0);
    check("t1_valids", nv, 1);
    check("t1_protocol", nvi, 0);

    // Halving rolloff: 32766+16383+8191+4095 = 61435, >>>4 = 3839.
    fill(16'sd32767);
    run_period(8'd3, 16'h8000, -1, -1, -1, lat, smp, np, nv, nvi);
    check("t2_latency", lat, 25);
    check("t2_sample", smp, 3839);
    check("t2_pulses", np, 4);
    check("t2_pulse0", pulse_h[0], 1);
    check("t2_pulse1", pulse_h[1], 2);
    check("t2_pulse2", pulse_h[2], 3);
    check("t2_pulse3", pulse_h[3], 0);
    check("t2_protocol", nvi, 0);

    // 64 harmonics of 32766 saturate high.
    run_period(8'd63, 16'h0000, -1, -1, -1, lat, smp, np, nv, nvi);
    check("t3_latency", lat, 385);
    check("t3_sample", smp, 32767);
    check("t3_pulses", np, 64);
    check("t3_pulse62", pulse_h[62], 63);
    check("t3_pulse63", pulse_h[63], 0);
    check("t3_protocol", nvi, 0);

    // Count above the maximum is clamped to 64; -32768 each saturates low.
    fill(16'sh8000);
    run_period(8'd255, 16'h0000, -1, -1, -1, lat, smp, np, nv, nvi);
    check("t3b_sample", smp, -32768);
    check("t3b_pulses", np, 64);
    check("t3b_latency", lat, 385);

    // Frequency limit at harmonic 4: 999-2000+2999+3999 = 5997, >>>4 = 374.
    fill(16'sd0);
    vals[0] = 16'sd1000; vals[1] = -16'sd2000; vals[2] = 16'sd3000;
    vals[3] = 16'sd4000; vals[4] = 16'sd5000; vals[5] = 16'sd6000;
    run_period(8'd10, 16'h0000, 4, -1, -1, lat, smp, np, nv, nvi);
    check("t4_sample", smp, 374);
    check("t4_pulses", np, 5);
    check("t4_pulse3", pulse_h[3], 4);
    check("t4_pulse4", pulse_h[4], 0);
    check("t4_latency", lat, 31);
    check("t4_protocol", nvi, 0);

    // Tick while busy: ignored, overrun sticks, period still completes once.
    fill(16'sd16384);
    run_period(8'd0, 16'h0000, -1, 3, -1, lat, smp, np, nv, nvi);
    check("t5_overrun", o_Overrun, 1);
    check("t5_latency", lat, 7);
    check("t5_sample", smp, 1023);
    check("t5_valids", nv, 1);
    step();
    check("t5_overrun_sticky", o_Overrun, 1);

    // Reset during WAIT_LUT of harmonic 2.
    run_period(8'd10, 16'h0000, -1, -1, 2, lat, smp, np, nv, nvi);
    check("t6_pulses_before", np, 2);
    check("t6_harmonic", o_Harmonic, 0);
    check("t6_next", o_Next_Sample, 0);
    check("t6_busy", o_Busy, 0);
    check("t6_overrun", o_Overrun, 0);
    check("t6_sample", o_Sample, 0);
    i_Reset = 1'b0;
    step();
    check("t6_idle_next", o_Next_Sample, 0);
    check("t6_idle_busy", o_Busy, 0);

    // Restart after reset begins at harmonic 0.
    run_period(8'd0, 16'h0000, -1, -1, -1, lat, smp, np, nv, nvi);
    check("t7_latency", lat, 7);
    check("t7_sample", smp, 1023);
    check("t7_pulse_harm", pulse_h[0], 0);
    check("t7_pulses", np, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/harmonic_scheduler.md
# harmonic_scheduler

Sequences the per-harmonic sample-position/sine-LUT datapath once per output sample period. On each sample-rate tick it walks harmonic indices 0..N-1 through the position block's ready/next handshake. It weights each returned sine value by a geometrically decaying amplitude and sums the weighted values. It presents one saturated mixed sample to the DAC/output stage. The block sits between the sample-rate timer and the sample-position block, and is the only driver of that block's harmonic address and next-sample strobe.

## Interface
- MAX_HARMONICS, 64, harmonics per sample period (1..256)
- ACC_W, 25, accumulator width in bits

- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high
- i_Sample_Tick  in  1  one-cycle pulse that starts a sample period
- i_Harmonic_Count  in  8  harmonics to sum, minus 1; clamped to MAX_HARMONICS-1
- i_Rolloff  in  16  amplitude decay per harmonic, unsigned Q0.16
- o_Harmonic  out  8  harmonic address to the position block
- i_Sample_Ready  in  1  position block has loaded the LUT address
- o_Next_Sample  out  1  one-cycle pulse: value consumed, advance
- i_Sample_Value  in  16  signed sine value; valid one cycle after i_Sample_Ready is first seen high
- i_Freq_Too_High  in  1  current harmonic frequency exceeds the limit
- o_Sample  out  16  signed mixed output sample
- o_Sample_Valid  out  1  one-cycle pulse when o_Sample updates
- o_Busy  out  1  high from tick accept until o_Sample_Valid
- o_Overrun  out  1  sticky: a tick arrived while busy; cleared only by reset

## Operation
- Reset values: o_Harmonic=0, o_Next_Sample=0, o_Sample=0, o_Sample_Valid=0, o_Busy=0, o_Overrun=0, state=IDLE, accumulator=0, scale=0xFFFF.
- IDLE: on i_Sample_Tick: clear the accumulator, set scale=0xFFFF and o_Harmonic=0, raise o_Busy, go to WAIT_READY.
- WAIT_READY: hold until i_Sample_Ready=1, then go to WAIT_LUT.
- WAIT_LUT: one cycle for the registered LUT output, then go to ACCUM.
- ACCUM:
  - If i_Freq_Too_High=1, skip the addition and flag the sample as last.
  - Otherwise acc += (signed(i_Sample_Value) * {1'b0,scale}) >>> 16, sign-extended to ACC_W.
  - Update scale <= scale - ((scale * i_Rolloff) >> 16). The result is unsigned 16-bit and cannot underflow.
  - Go to NEXT.
- NEXT:
  - Pulse o_Next_Sample.
  - If this is the last harmonic (o_Harmonic == min(i_Harmonic_Count, MAX_HARMONICS-1), or the sample was flagged last), drive o_Harmonic=0 in the same cycle and go to OUTPUT.
  - Otherwise drive o_Harmonic+1 and go to WAIT_READY.
  - o_Harmonic must read 0 when o_Next_Sample is high on the final harmonic, so the position block reinitialises.
- OUTPUT: o_Sample <= saturate16(acc >>> 4), clamped to [-32768, 32767]. Pulse o_Sample_Valid, drop o_Busy, go to IDLE.
- i_Sample_Tick while o_Busy=1: the tick is ignored and o_Overrun is set. A tick in the same cycle as o_Sample_Valid also counts as overrun.
- i_Harmonic_Count is sampled at tick accept. Changes mid-period do not apply until the next tick.
- Reset mid-operation: return to IDLE immediately with reset values. No o_Next_Sample is issued.

## Timing
- Per harmonic: 1 cycle WAIT_READY, plus the position block's ready delay, plus 1 WAIT_LUT, 1 ACCUM and 1 NEXT.
- With a position-block ready delay of 3 cycles, one harmonic takes 6 cycles.
- Tick to o_Sample_Valid = H*(per-harmonic cycles) + 1 cycle, where H is the number of harmonics processed.
- o_Next_Sample is never high on two consecutive cycles. It is only issued after i_Sample_Ready has been seen high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - state encoding: IDLE, WAIT_READY, WAIT_LUT, ACCUM, NEXT, OUTPUT
  - SCALE_INIT=16'hFFFF
  - OUT_SHIFT=4
  - 16-bit saturation limits
- One sub-module, harmonic_weight: a registered signed×unsigned 16×16 multiply returning product>>>16. It is used for both the sample weighting and the scale decay, either time-shared or instantiated twice.

## Test plan
- Tick; count=0; rolloff=0; position model returns 16384 with ready delay 3 → one o_Next_Sample with o_Harmonic=0; o_Sample=1023 (16384*65535>>16 = 16383, >>>4); valid 7 cycles after tick.
- count=3; rolloff=0x8000; all samples=32767 → scales 65535, 32768, 16384, 8192; o_Harmonic sequence 0,1,2,3, then 0 on the final next pulse.
- count=63; rolloff=0; all samples=32767 → accumulator ≈ 64*32766, and o_Sample saturates to 32767. With all samples=-32768 → o_Sample=-32768.
- count=10; i_Freq_Too_High asserted on harmonic 4 → harmonics 0..3 summed, harmonic 4 excluded; 5 o_Next_Sample pulses; o_Harmonic=0 at the last one.
- Second tick while busy → o_Overrun=1 and stays high; the period completes normally with exactly one o_Sample_Valid.
- Reset asserted during WAIT_LUT of harmonic 2 → the next cycle shows IDLE, all outputs at reset values, no o_Next_Sample; the next tick restarts at harmonic 0.
